// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl
// Request front-end for a single-port SRAM macro with a one-cycle read latency.
// Independent write and read request channels (valid/ready) are arbitrated onto
// the one SRAM port. When both channels compete, a toggling priority bit decides
// the winner. Addresses are range-checked. Read data comes back on a buffered
// response channel that tolerates backpressure.
//
// Ports
//   clock, reset            sole clock (rising edge); synchronous active-high reset
//   wr_valid/wr_ready       write request handshake; wr_addr, wr_data payload
//   rd_valid/rd_ready       read request handshake; rd_addr payload
//   resp_valid/resp_ready   read response handshake; resp_data, resp_err payload
//   wr_oor_cnt              saturating count of dropped out-of-range writes
//   sram_en, sram_wmode     macro enable and write mode (1 = write)
//   sram_addr, sram_wdata   macro address and write data
//   sram_rdata              macro read data, valid in the cycle after a read issue
module sram_rw_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 12288,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic [15:0]           wr_oor_cnt,
  output logic                  sram_en,
  output logic                  sram_wmode,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L      = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CW:0]         RESP_DEPTH_L = (CW + 1)'(RESP_DEPTH);

  // Response FIFO is a shift register: entry 0 is always the head, so the
  // response outputs come straight from flops and stay put while stalled.
  logic [DATA_WIDTH-1:0] fifo_data_r [RESP_DEPTH];
  logic                  fifo_err_r  [RESP_DEPTH];
  logic [CW-1:0]         fifo_count_r;
  logic [DATA_WIDTH-1:0] fifo_data_s [RESP_DEPTH];
  logic                  fifo_err_s  [RESP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_up_data_s [RESP_DEPTH];
  logic                  fifo_up_err_s  [RESP_DEPTH];
  logic [CW-1:0]         fifo_count_s;
  logic [CW-1:0]         push_idx_s;
  logic [DATA_WIDTH-1:0] push_data_s;

  logic                  inflight_r;
  logic                  inflight_err_r;
  logic                  prio_wr_r;

  logic                  pop_s;
  logic [CW:0]           occ_s;
  logic                  rd_can_s;
  logic                  rd_elig_s;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic                  wr_inr_s;
  logic                  rd_inr_s;

  assign resp_valid = (fifo_count_r != {CW{1'b0}});
  assign resp_data  = fifo_data_r[0];
  assign resp_err   = fifo_err_r[0];
  assign pop_s      = resp_valid & resp_ready;
  assign wr_inr_s   = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_inr_s   = ({1'b0, rd_addr} < DEPTH_L);

  // Read admission and arbitration. A ready never looks at its own valid, only
  // at the other channel's valid, so there is no combinational loop through
  // the requester.
  always_comb begin
    occ_s     = {1'b0, fifo_count_r} + (CW + 1)'(inflight_r) - (CW + 1)'(pop_s);
    rd_can_s  = (occ_s < RESP_DEPTH_L);
    rd_elig_s = rd_valid & rd_can_s;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    if (reset) begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
    end else begin
      wr_ready = ~rd_elig_s | prio_wr_r;
      rd_ready = rd_can_s & (~wr_valid | ~prio_wr_r);
    end
    wr_fire_s = wr_valid & wr_ready;
    rd_fire_s = rd_valid & rd_ready;
  end

  // Drive the macro port in the accept cycle; out-of-range requests keep it idle.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = rd_addr;
    sram_wdata = wr_data;
    if (wr_fire_s) begin
      sram_en    = wr_inr_s;
      sram_wmode = 1'b1;
      sram_addr  = wr_addr;
    end else if (rd_fire_s) begin
      sram_en    = rd_inr_s;
    end else begin
      sram_en    = 1'b0;
    end
  end

  // Next FIFO state: a pop shifts toward the head, and a push lands just behind
  // the surviving entries. This lets a push and a pop share a cycle.
  always_comb begin
    push_idx_s   = fifo_count_r - CW'(pop_s);
    fifo_count_s = fifo_count_r + CW'(inflight_r) - CW'(pop_s);
    push_data_s  = inflight_err_r ? {DATA_WIDTH{1'b0}} : sram_rdata;
    for (int i = 0; i < RESP_DEPTH - 1; i++) begin
      fifo_up_data_s[i] = fifo_data_r[i+1];
      fifo_up_err_s[i]  = fifo_err_r[i+1];
    end
    fifo_up_data_s[RESP_DEPTH-1] = {DATA_WIDTH{1'b0}};
    fifo_up_err_s[RESP_DEPTH-1]  = 1'b0;
    for (int i = 0; i < RESP_DEPTH; i++) begin
      fifo_data_s[i] = fifo_data_r[i];
      fifo_err_s[i]  = fifo_err_r[i];
      if (inflight_r && (CW'(i) == push_idx_s)) begin
        fifo_data_s[i] = push_data_s;
        fifo_err_s[i]  = inflight_err_r;
      end else if (pop_s) begin
        fifo_data_s[i] = fifo_up_data_s[i];
        fifo_err_s[i]  = fifo_up_err_s[i];
      end else begin
        fifo_data_s[i] = fifo_data_r[i];
        fifo_err_s[i]  = fifo_err_r[i];
      end
    end
  end

  // FIFO storage and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_count_r <= {CW{1'b0}};
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
        fifo_err_r[i]  <= 1'b0;
      end
    end else begin
      fifo_count_r <= fifo_count_s;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_data_r[i] <= fifo_data_s[i];
        fifo_err_r[i]  <= fifo_err_s[i];
      end
    end
  end

  // In-flight stage, conflict priority and out-of-range write counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_r     <= 1'b0;
      inflight_err_r <= 1'b0;
      prio_wr_r      <= 1'b1;
      wr_oor_cnt     <= 16'h0000;
    end else begin
      inflight_r     <= rd_fire_s;
      inflight_err_r <= rd_fire_s & ~rd_inr_s;
      // Priority flips only when both channels were actually competing.
      if (wr_valid && rd_elig_s) begin
        prio_wr_r <= ~prio_wr_r;
      end else begin
        prio_wr_r <= prio_wr_r;
      end
      if (wr_fire_s && !wr_inr_s && (wr_oor_cnt != 16'hFFFF)) begin
        wr_oor_cnt <= wr_oor_cnt + 16'h0001;
      end else begin
        wr_oor_cnt <= wr_oor_cnt;
      end
    end
  end

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Self-checking bench for sram_rw_ctrl. It holds a behavioural SRAM macro and
// a reference model made of a response queue and a sparse memory. The driver
// applies inputs on the falling edge and checks the handshake and the SRAM pins
// against the model. A separate monitor compares responses against the queue.
module tb_sram_rw_ctrl;
  localparam int AW    = 14;
  localparam int DW    = 64;
  localparam int DEPTH = 12288;
  localparam int RD    = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0, rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          resp_valid, resp_ready = 1'b0;
  logic [DW-1:0] resp_data;
  logic          resp_err;
  logic [15:0]   wr_oor_cnt;
  logic          sram_en, sram_wmode;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  sram_rw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESP_DEPTH(RD)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .wr_oor_cnt(wr_oor_cnt),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural macro: write on the edge, read data registered and held.
  logic [DW-1:0] sram_m [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) sram_m[i] = '0;
  always @(posedge clock) begin
    if (sram_en && int'(sram_addr) < DEPTH) begin
      if (sram_wmode) sram_m[sram_addr] <= sram_wdata;
      else            sram_rdata <= sram_m[sram_addr];
    end
  end

  typedef struct { int due; logic [DW-1:0] data; logic err; } resp_t;
  resp_t         sb_q[$];
  logic [DW-1:0] ref_mem [int];
  bit            prio_m = 1'b1;
  int            oor_m = 0;
  bit            prev_rst = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_lookup(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return '0;
  endfunction

  // One clock of stimulus plus the handshake/pin checks for that cycle.
  task automatic step(input bit rst, input bit wv, input int wa, input logic [DW-1:0] wd,
                      input bit rv, input int ra, input bit rr);
    bit head_rdy, pop_m, rd_can, rd_want, gw, gr, inr;
    @(negedge clock);
    reset = rst; wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
    rd_valid = rv; rd_addr = AW'(ra); resp_ready = rr;
    #2;
    if (prev_rst && !rst) begin
      check("rst_resp_data", resp_data, '0);
      check("rst_resp_err", {63'd0, resp_err}, '0);
      check("rst_oor_cnt", {48'd0, wr_oor_cnt}, '0);
    end
    prev_rst = rst;
    if (rst) begin
      check("rst_wr_ready", {63'd0, wr_ready}, '0);
      check("rst_rd_ready", {63'd0, rd_ready}, '0);
      check("rst_sram_en", {63'd0, sram_en}, '0);
      sb_q.delete();
      prio_m = 1'b1;
      oor_m  = 0;
    end else begin
      check("wr_oor_cnt", {48'd0, wr_oor_cnt}, DW'(oor_m));
      head_rdy = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
      pop_m    = head_rdy && rr;
      rd_can   = (sb_q.size() - int'(pop_m)) < RD;
      rd_want  = rv && rd_can;
      if (wv && rd_want) begin
        gw = prio_m; gr = !prio_m; prio_m = !prio_m;
      end else begin
        gw = wv; gr = rd_want;
      end
      if (wv) check("wr_ready", {63'd0, wr_ready}, {63'd0, gw});
      if (rv) check("rd_ready", {63'd0, rd_ready}, {63'd0, gr});
      if (gw) begin
        inr = (wa < DEPTH);
        check("wr_sram_en", {63'd0, sram_en}, {63'd0, inr});
        if (inr) begin
          check("wr_sram_wmode", {63'd0, sram_wmode}, 64'd1);
          check("wr_sram_addr", {50'd0, sram_addr}, DW'(wa));
          check("wr_sram_wdata", sram_wdata, wd);
          ref_mem[wa] = wd;
        end else if (oor_m < 65535) begin
          oor_m++;
        end
      end else if (gr) begin
        inr = (ra < DEPTH);
        check("rd_sram_en", {63'd0, sram_en}, {63'd0, inr});
        if (inr) begin
          check("rd_sram_wmode", {63'd0, sram_wmode}, 64'd0);
          check("rd_sram_addr", {50'd0, sram_addr}, DW'(ra));
        end
        sb_q.push_back('{cyc + 2, inr ? mem_lookup(ra) : '0, !inr});
      end else begin
        check("idle_sram_en", {63'd0, sram_en}, 64'd0);
      end
    end
  endtask

  // Response monitor: valid must match the head's due time, payload the head.
  initial begin
    bit exp_v;
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        exp_v = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
        check("resp_valid", {63'd0, resp_valid}, {63'd0, exp_v});
        if (exp_v) begin
          if (resp_valid) begin
            check("resp_data", resp_data, sb_q[0].data);
            check("resp_err", {63'd0, resp_err}, {63'd0, sb_q[0].err});
          end
          if (resp_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  function automatic int rand_addr();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      7:       return DEPTH - 1;
      8:       return DEPTH;
      9:       return $urandom_range(DEPTH, 16383);
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    // Reset, then write followed by a read of the same address.
    step(1, 0, 0, '0, 0, 0, 1);
    step(1, 0, 0, '0, 0, 0, 1);
    step(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 0, 1);
    step(0, 0, 0, '0, 1, 5, 1);
    repeat (3) step(0, 0, 0, '0, 0, 0, 1);

    // Competing channels from reset: W, R, W, R.
    step(1, 0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 8 + i, {$urandom, $urandom}, 1, 5, 1);
    repeat (3) step(0, 0, 0, '0, 0, 0, 1);

    // Backpressure: only RD reads admitted, then drain and stream.
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1, 8 + i, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, 1, i, 1);
    repeat (3) step(0, 0, 0, '0, 0, 0, 1);

    // Out-of-range read and write.
    step(0, 0, 0, '0, 1, 12288, 1);
    step(0, 1, 16383, 64'h1234, 0, 0, 1);
    repeat (3) step(0, 0, 0, '0, 0, 0, 1);

    // Reset with one response queued and one read in flight.
    step(0, 0, 0, '0, 1, 5, 0);
    step(0, 0, 0, '0, 1, 6, 0);
    step(1, 0, 0, '0, 1, 7, 0);
    repeat (3) step(0, 0, 0, '0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(0, 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom},
           1'($urandom_range(0, 1)), rand_addr(), ($urandom_range(0, 9) < 7));
    repeat (4) step(0, 0, 0, '0, 0, 0, 1);

    // Saturation of the out-of-range write counter.
    step(1, 0, 0, '0, 0, 0, 1);
    for (int i = 0; i < 65537; i++)
      step(0, 1, $urandom_range(DEPTH, 16383), '0, 0, 0, 1);
    step(0, 0, 0, '0, 0, 0, 1);
    check("oor_saturated", {48'd0, wr_oor_cnt}, 64'hFFFF);

    @(negedge clock);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
